// File: rtl/axi_hdr_pkg.sv
// Shared definitions for the header arbiter: FSM encoding and default sizes.
package axi_hdr_pkg;
  localparam int DATA_WD_DEF = 32;
  localparam int N_REQ_DEF   = 4;
  localparam int PKT_CNT_WD  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_HDR  = 2'd1,
    ST_WAIT_LAST = 2'd2
  } hdr_state_e;
endpackage

// File: rtl/hdr_rr_pick.sv
// Combinational round-robin pick: first set request after i_last, with wrap.
module hdr_rr_pick #(
  parameter int N_REQ  = 4,
  parameter int IDX_WD = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  i_req,
  input  logic [IDX_WD-1:0] i_last,
  output logic [IDX_WD-1:0] o_win,
  output logic              o_any
);
  // Scan farthest offset first so the nearest requester after i_last wins.
  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (i_req[j] && (j == ((int'(i_last) + k) % N_REQ))) begin
          o_win = IDX_WD'(j);
          o_any = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter granting one header requester per packet to the insert datapath.
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int N_REQ        = N_REQ_DEF,
  parameter int IDX_WD       = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WD-1:0]      req_data,
  input  logic [N_REQ*DATA_BYTE_WD-1:0] req_keep,
  input  logic [N_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          hdr_valid,
  output logic [DATA_WD-1:0]            hdr_data,
  output logic [DATA_BYTE_WD-1:0]       hdr_keep,
  output logic [BYTE_CNT_WD-1:0]        hdr_byte_cnt,
  input  logic                          hdr_ready,
  input  logic                          mon_valid,
  input  logic                          mon_ready,
  input  logic                          mon_last,
  output logic [IDX_WD-1:0]             grant_id,
  output logic                          busy,
  output logic [PKT_CNT_WD-1:0]         pkt_cnt
);
  hdr_state_e              r_state, w_state_nxt;
  logic [IDX_WD-1:0]       r_grant, r_last_grant, w_win;
  logic                    w_any, w_sel_valid, w_done;
  logic [PKT_CNT_WD-1:0]   r_pkt_cnt;

  hdr_rr_pick #(.N_REQ(N_REQ), .IDX_WD(IDX_WD)) u_pick (
    .i_req  (req_valid),
    .i_last (r_last_grant),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // Slice mux driven only by the registered grant.
  always_comb begin
    w_sel_valid  = 1'b0;
    hdr_data     = '0;
    hdr_keep     = '0;
    hdr_byte_cnt = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (r_grant == IDX_WD'(j)) begin
        w_sel_valid  = req_valid[j];
        hdr_data     = req_data[j*DATA_WD +: DATA_WD];
        hdr_keep     = req_keep[j*DATA_BYTE_WD +: DATA_BYTE_WD];
        hdr_byte_cnt = req_byte_cnt[j*BYTE_CNT_WD +: BYTE_CNT_WD];
      end
    end
  end

  assign w_done = mon_valid && mon_ready && mon_last;

  always_comb begin
    w_state_nxt = r_state;
    hdr_valid   = 1'b0;
    req_ready   = '0;
    unique case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_SEND_HDR;
      ST_SEND_HDR: begin
        hdr_valid = w_sel_valid;
        for (int j = 0; j < N_REQ; j++)
          req_ready[j] = (r_grant == IDX_WD'(j)) && hdr_ready;
        if (w_sel_valid && hdr_ready) w_state_nxt = ST_WAIT_LAST;
      end
      ST_WAIT_LAST: if (w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= IDX_WD'(N_REQ - 1);
      r_last_grant <= IDX_WD'(N_REQ - 1);
      r_pkt_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) r_grant <= w_win;
      if (r_state == ST_WAIT_LAST && w_done) begin
        r_last_grant <= r_grant;
        r_pkt_cnt    <= r_pkt_cnt + 1'b1;
      end
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign pkt_cnt  = r_pkt_cnt;
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed bench for the header arbiter with hand-computed expectations.
module tb_axi_stream_header_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [15:0] req_keep;
  logic [7:0]  req_byte_cnt;
  logic [3:0]  req_ready;
  logic        hdr_valid;
  logic [31:0] hdr_data;
  logic [3:0]  hdr_keep;
  logic [1:0]  hdr_byte_cnt;
  logic        hdr_ready;
  logic        mon_valid, mon_ready, mon_last;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] pkt_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_stream_header_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
    .req_byte_cnt(req_byte_cnt), .req_ready(req_ready),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_keep(hdr_keep),
    .hdr_byte_cnt(hdr_byte_cnt), .hdr_ready(hdr_ready),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input logic v);
    mon_valid = v;
    mon_ready = v;
    mon_last  = v;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 4'b0000;
    req_data     = {32'hD3D3_0303, 32'hD2D2_0202, 32'hD1D1_0101, 32'hD0D0_0000};
    req_keep     = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
    req_byte_cnt = {2'd3, 2'd2, 2'd1, 2'd0};
    hdr_ready    = 1'b0;
    mon(1'b0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_grant",     32'(grant_id),  32'd3);
    chk("rst_pkt_cnt",   32'(pkt_cnt),   32'd0);

    // single requester 0, ready asserted
    tick();
    req_valid = 4'b0001;
    hdr_ready = 1'b1;
    @(negedge clk);
    chk("idle_no_comb_valid", 32'(hdr_valid), 32'd0);
    chk("idle_no_ready",      32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("r0_hdr_valid", 32'(hdr_valid),    32'd1);
    chk("r0_hdr_data",  hdr_data,          32'hD0D0_0000);
    chk("r0_hdr_keep",  32'(hdr_keep),     32'h1);
    chk("r0_byte_cnt",  32'(hdr_byte_cnt), 32'd0);
    chk("r0_req_ready", 32'(req_ready),    32'b0001);
    chk("r0_grant",     32'(grant_id),     32'd0);
    chk("r0_busy",      32'(busy),         32'd1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("wait_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    chk("wait_busy",      32'(busy),      32'd1);
    tick();
    mon(1'b1);
    tick();
    mon(1'b0);
    @(negedge clk);
    chk("done0_busy",    32'(busy),     32'd0);
    chk("done0_pkt_cnt", 32'(pkt_cnt),  32'd1);
    chk("done0_grant",   32'(grant_id), 32'd0);

    // completion beat in IDLE ignored
    mon(1'b1);
    tick();
    mon(1'b0);
    @(negedge clk);
    chk("idle_mon_busy", 32'(busy),    32'd0);
    chk("idle_mon_cnt",  32'(pkt_cnt), 32'd1);

    // requester 1 with 3 stalled cycles; a mon beat lands during the stall
    tick();
    req_valid = 4'b0010;
    hdr_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      mon(c == 1);
      @(negedge clk);
      chk("stall_hdr_valid", 32'(hdr_valid), 32'd1);
      chk("stall_grant",     32'(grant_id),  32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_pkt_cnt",   32'(pkt_cnt),   32'd1);
      chk("stall_hdr_data",  hdr_data,       32'hD1D1_0101);
      tick();
    end
    mon(1'b0);
    hdr_ready = 1'b1;
    @(negedge clk);
    chk("hs_req_ready", 32'(req_ready), 32'b0010);
    chk("hs_hdr_valid", 32'(hdr_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("hs_wait_valid", 32'(hdr_valid), 32'd0);

    // completion coincides with requester 2 pending
    req_valid = 4'b0100;
    mon(1'b1);
    tick();
    mon(1'b0);
    @(negedge clk);
    chk("gap_busy",      32'(busy),      32'd0);
    chk("gap_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("gap_grant",     32'(grant_id),  32'd1);
    chk("gap_pkt_cnt",   32'(pkt_cnt),   32'd2);
    tick();
    @(negedge clk);
    chk("r2_grant",     32'(grant_id),  32'd2);
    chk("r2_hdr_valid", 32'(hdr_valid), 32'd1);
    chk("r2_hdr_data",  hdr_data,       32'hD2D2_0202);
    chk("r2_hdr_keep",  32'(hdr_keep),  32'h7);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("r2_wait_busy", 32'(busy), 32'd1);

    // reset during WAIT_LAST with grant 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_cnt",   32'(pkt_cnt),  32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd3);

    // all requesting: 0,1,2,3,0
    req_valid = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      tick();
      @(negedge clk);
      chk("rr_grant",     32'(grant_id),  32'(p % 4));
      chk("rr_hdr_valid", 32'(hdr_valid), 32'd1);
      tick();
      mon(1'b1);
      tick();
      mon(1'b0);
      @(negedge clk);
      chk("rr_idle_busy", 32'(busy), 32'd0);
    end
    chk("rr_pkt_cnt", 32'(pkt_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
